// File: rtl/cla_mp_sequencer.sv
// Multi-precision adder sequencer. Walks an operand pair limb by limb
// through an external 9-bit carry-lookahead adder that has no carry-in:
// a limb entered with carry=0 takes one ADD pass, a limb entered with
// carry=1 takes an ADD pass followed by an INC pass that adds the carry.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. The request side (i_valid/o_ready) is accepted only in IDLE.
// The result side (o_valid/i_ready) holds o_result/o_passes stable
// until i_ready is seen. Neither side queues anything.
module cla_mp_sequencer #(
  parameter int NUM_LIMBS = 4,
  localparam int W = 9 * NUM_LIMBS
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_add1,
  input  logic [W-1:0] i_add2,
  input  logic         i_cin,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W:0]   o_result,
  output logic [3:0]   o_passes,
  output logic [8:0]   o_alu_a,
  output logic [8:0]   o_alu_b,
  input  logic [9:0]   i_alu_sum,
  output logic [1:0]   dbg_state
);

  localparam int RW = W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] a_q, b_q;
  logic [2:0]   k;
  logic         carry;
  // One bit wider than o_passes so NUM_LIMBS=8 with all carries (16) is
  // counted correctly internally; the port shows the low four bits.
  logic [4:0]   passes;
  logic [9:0]   tmp;
  logic [W:0]   res;

  logic [6:0]   base;
  logic [8:0]   a_limb, b_limb;
  logic         last;
  logic         new_carry;
  logic [W:0]   res_commit;

  assign base      = 7'(k) * 7'd9;
  assign a_limb    = 9'(a_q >> base);
  assign b_limb    = 9'(b_q >> base);
  assign last      = (k == 3'(NUM_LIMBS - 1));
  assign dbg_state = state;

  // Result is exposed only while it is complete, so an aborted or
  // in-flight transaction never shows a partial sum.
  assign o_result = (state == DONE) ? res : '0;
  assign o_passes = (state == DONE) ? passes[3:0] : 4'd0;

  // Limb commit: the INC pass merges the carry out of both passes.
  always_comb begin
    new_carry  = (state == INC) ? (tmp[9] | i_alu_sum[9]) : i_alu_sum[9];
    res_commit = (res & ~(RW'(9'h1FF) << base)) | (RW'(i_alu_sum[8:0]) << base);
    if (last) res_commit[W] = new_carry;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and adder operand / handshake outputs.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_alu_a   = 9'd0;
    o_alu_b   = 9'd0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = ADD;
      end
      ADD: begin
        o_alu_a = a_limb;
        o_alu_b = b_limb;
        if (carry)     state_nxt = INC;
        else if (last) state_nxt = DONE;
        else           state_nxt = ADD;
      end
      INC: begin
        o_alu_a   = tmp[8:0];
        o_alu_b   = 9'd1;
        state_nxt = last ? DONE : ADD;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, per-pass datapath and pass counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      k      <= 3'd0;
      carry  <= 1'b0;
      passes <= 5'd0;
      tmp    <= 10'd0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q    <= i_add1;
            b_q    <= i_add2;
            carry  <= i_cin;
            k      <= 3'd0;
            passes <= 5'd0;
            res    <= '0;
          end
        end
        ADD: begin
          tmp    <= i_alu_sum;
          passes <= passes + 5'd1;
          if (!carry) begin
            res   <= res_commit;
            carry <= new_carry;
            if (!last) k <= k + 3'd1;
          end
        end
        INC: begin
          res    <= res_commit;
          carry  <= new_carry;
          passes <= passes + 5'd1;
          if (!last) k <= k + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Bench for cla_mp_sequencer (NUM_LIMBS=4): directed literal cases,
// reset during an INC pass, backpressure, then randomized requests.
module tb_cla_mp_sequencer;

  localparam int NL = 4;
  localparam int W  = 9 * NL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_valid, o_ready, cin, o_valid, i_ready;
  logic [W-1:0]  add1, add2;
  logic [W:0]    result;
  logic [3:0]    passes;
  logic [8:0]    alu_a, alu_b;
  logic [9:0]    alu_sum;
  logic [1:0]    dbg_state;

  // External combinational 9-bit CLA.
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  cla_mp_sequencer #(.NUM_LIMBS(NL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_add1(add1), .i_add2(add2), .i_cin(cin),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(result), .o_passes(passes),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .i_alu_sum(alu_sum),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Sum by plain arithmetic; the pass schedule follows the carry chain:
  // every limb gets an add pass, and one extra +1 pass if it is entered
  // with a carry.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic c, output logic [W:0] sum,
                                    output int np, output logic [143:0] sa,
                                    output logic [143:0] sb);
    logic       cy;
    logic [8:0] la, lb;
    logic [9:0] s, t;
    sum = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    cy  = c;
    np  = 0;
    sa  = '0;
    sb  = '0;
    for (int k = 0; k < NL; k++) begin
      la = 9'(a >> (9 * k));
      lb = 9'(b >> (9 * k));
      s  = {1'b0, la} + {1'b0, lb};
      sa = sa | (144'(la) << (9 * np));
      sb = sb | (144'(lb) << (9 * np));
      np++;
      if (cy) begin
        sa = sa | (144'(s[8:0]) << (9 * np));
        sb = sb | (144'(9'd1) << (9 * np));
        np++;
      end
      t  = s + 10'(cy);
      cy = t[9];
    end
  endfunction

  logic [W:0]   cur_res;
  int           cur_np;
  logic [143:0] cur_sa, cur_sb;
  always_comb ref_model(add1, add2, cin, cur_res, cur_np, cur_sa, cur_sb);

  // Model state: 0 idle, 1 busy (passes in progress), 2 result held.
  int           m_state  = 0;
  int           acc_edge = 0;
  int           done_at  = 0;
  logic [W:0]   m_res;
  int           m_np;
  logic [143:0] m_sa, m_sb;
  bit           model_ok = 1'b0;
  logic [W:0]   exp_q[$];

  // Model advances on each edge from the inputs the DUT samples.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_state  <= 0;
      model_ok <= 1'b1;
      exp_q.delete();
    end else begin
      case (m_state)
        0: if (i_valid) begin
          m_res    <= cur_res;
          m_np     <= cur_np;
          m_sa     <= cur_sa;
          m_sb     <= cur_sb;
          acc_edge <= cyc + 1;
          done_at  <= cyc + 1 + cur_np;
          m_state  <= 1;
          exp_q.push_back(cur_res);
        end
        1: if (cyc + 1 == done_at) m_state <= 2;
        2: if (i_ready) m_state <= 0;
        default: m_state <= 0;
      endcase
    end
  end

  // Cycle-by-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      int p;
      logic [W:0] e;
      chk("ready", 64'(o_ready), 64'(m_state == 0));
      chk("valid", 64'(o_valid), 64'(m_state == 2));
      if (m_state == 1) begin
        p = cyc - acc_edge;
        chk("alu_a", 64'(alu_a), 64'(9'(m_sa >> (9 * p))));
        chk("alu_b", 64'(alu_b), 64'(9'(m_sb >> (9 * p))));
      end else begin
        chk("alu_a_zero", 64'(alu_a), 64'd0);
        chk("alu_b_zero", 64'(alu_b), 64'd0);
      end
      if (m_state == 2) begin
        chk("result", 64'(result), 64'(m_res));
        chk("passes", 64'(passes), 64'(m_np));
        if (i_ready) begin
          chk("sb_depth", 64'(exp_q.size()), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_result", 64'(result), 64'(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r = '0;
    logic [8:0]   l;
    for (int k = 0; k < NL; k++) begin
      case ($urandom_range(0, 2))
        0:       l = 9'h1FF;
        1:       l = 9'($urandom);
        default: l = 9'h000;
      endcase
      r = r | (W'(l) << (9 * k));
    end
    return r;
  endfunction

  task automatic noise();
    i_valid = ($urandom_range(0, 2) == 0);
    add1    = rand_op();
    add2    = rand_op();
    cin     = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", 64'(o_ready), 64'd1);
  endtask

  // One full transaction with noise on unused inputs while busy/held.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input int hold, input bit lit, input logic [W:0] lres,
                      input int lpass, input int llat);
    int lat;
    logic [W:0] rs;
    int np;
    logic [143:0] sa, sb;
    ref_model(a, b, c, rs, np, sa, sb);
    wait_ready();
    i_valid = 1'b1; add1 = a; add2 = b; cin = c;
    i_ready = 1'($urandom);
    @(posedge clk); #1;
    lat = 1;
    while (!o_valid && lat < 40) begin
      noise();
      i_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(np + 1));
    if (lit) begin
      chk("lit_result", 64'(result), 64'(lres));
      chk("lit_passes", 64'(passes), 64'(lpass));
      chk("lit_latency", 64'(lat), 64'(llat));
    end
    for (int i = 0; i < hold; i++) begin
      noise();
      i_ready = 1'b0;
      @(posedge clk); #1;
    end
    if (lit) chk("lit_held_result", 64'(result), 64'(lres));
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    if (lit) chk("ready_after_done", 64'(o_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    add1 = '0; add2 = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready",  64'(o_ready), 64'd1);
    chk("rst_valid",  64'(o_valid), 64'd0);
    chk("rst_result", 64'(result),  64'd0);
    chk("rst_passes", 64'(passes),  64'd0);

    // Simple add, with backpressure of 5 cycles and ignored valid pulses.
    send(36'h000000001, 36'h000000001, 1'b0, 5, 1'b1, 37'h0000000002, 4, 5);
    // Carry ripples through every upper limb.
    send(36'hFFFFFFFFF, 36'h000000001, 1'b0, 0, 1'b1, 37'h1000000000, 7, 8);
    // Every limb entered with carry.
    send(36'hFFFFFFFFF, 36'hFFFFFFFFF, 1'b1, 2, 1'b1, 37'h1FFFFFFFFF, 8, 9);
    // Carry-in only.
    send(36'h000000000, 36'h000000000, 1'b1, 1, 1'b1, 37'h0000000001, 5, 6);

    // Reset during the INC pass of limb 1.
    wait_ready();
    i_valid = 1'b1; add1 = 36'hFFFFFFFFF; add2 = 36'h000000001; cin = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("inc_alu_a", 64'(alu_a), 64'h1FF);
    chk("inc_alu_b", 64'(alu_b), 64'd1);
    rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    chk("abort_ready",  64'(o_ready), 64'd1);
    chk("abort_valid",  64'(o_valid), 64'd0);
    chk("abort_result", 64'(result),  64'd0);
    chk("abort_passes", 64'(passes),  64'd0);
    chk("abort_alu_a",  64'(alu_a),   64'd0);
    chk("abort_alu_b",  64'(alu_b),   64'd0);
    send(36'h000000123, 36'h000000456, 1'b0, 0, 1'b1, 37'h0000000579, 4, 5);

    // Randomized requests with random result stalls.
    for (int t = 0; t < 6000; t++) begin
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
           1'b0, '0, 0, 0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
